// File: rtl/double_buffer_writer.sv
// Write-side controller for the pixel double buffer. Each frame is streamed into the bank the reader does not own, then handed over.
// Optional build macro DOUBLE_BUFFER_STATS_EN adds a saturating droppedCount output.
module double_buffer_writer #(
  parameter int DATA_WIDTH    = 10,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic                     frameStart,
  input  logic                     frameEnd,
  input  logic                     pixelValid,
  input  logic [DATA_WIDTH-1:0]    pixelData,
  input  logic                     readerRelease,
  output logic                     writeEnableA,
  output logic [ADDRESS_WIDTH:0]   addressA,
  output logic [DATA_WIDTH-1:0]    dataInA,
  output logic                     frameReady,
  output logic                     readBank,
  output logic [ADDRESS_WIDTH:0]   frameLength,
`ifdef DOUBLE_BUFFER_STATS_EN
  output logic                     droppedFrame,
  output logic [15:0]              droppedCount
`else
  output logic                     droppedFrame
`endif
);

  typedef enum logic [1:0] {IDLE, WRITE, OVERRUN} writerState;

  localparam logic [ADDRESS_WIDTH:0] CAPACITY = {1'b1, {ADDRESS_WIDTH{1'b0}}};
  localparam logic [ADDRESS_WIDTH:0] ONE      = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

  writerState                state, stateNext;
  logic [ADDRESS_WIDTH:0]    wordCount, wordCountNext;
  logic                      writeEnableNext;
  logic [ADDRESS_WIDTH:0]    addressNext;
  logic [DATA_WIDTH-1:0]     dataNext;
  logic                      frameReadyNext;
  logic                      readyPending, readyPendingNext;
  logic                      readBankNext;
  logic [ADDRESS_WIDTH:0]    frameLengthNext;
  logic                      droppedNext;
  logic                      frameDone;
  logic [ADDRESS_WIDTH:0]    finalCount;
  logic                      released;
  logic                      handover;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      wordCount    <= '0;
      writeEnableA <= 1'b0;
      addressA     <= '0;
      dataInA      <= '0;
      frameReady   <= 1'b0;
      readyPending <= 1'b0;
      readBank     <= 1'b0;
      frameLength  <= '0;
      droppedFrame <= 1'b0;
    end else begin
      state        <= stateNext;
      wordCount    <= wordCountNext;
      writeEnableA <= writeEnableNext;
      addressA     <= addressNext;
      dataInA      <= dataNext;
      frameReady   <= frameReadyNext;
      readyPending <= readyPendingNext;
      readBank     <= readBankNext;
      frameLength  <= frameLengthNext;
      droppedFrame <= droppedNext;
    end
  end

  always_comb begin
    stateNext       = state;
    wordCountNext   = wordCount;
    writeEnableNext = 1'b0;
    addressNext     = addressA;
    dataNext        = dataInA;
    droppedNext     = 1'b0;
    frameDone       = 1'b0;
    finalCount      = wordCount;

    // A restart outranks a same-cycle frameEnd while a frame is already open
    if (frameStart) begin
      stateNext     = WRITE;
      wordCountNext = '0;
      droppedNext   = (state != IDLE);
      if (pixelValid) begin
        writeEnableNext = 1'b1;
        addressNext     = {~readBank, {ADDRESS_WIDTH{1'b0}}};
        dataNext        = pixelData;
        wordCountNext   = ONE;
      end
      if (frameEnd && state == IDLE) begin
        frameDone  = 1'b1;
        finalCount = wordCountNext;
        stateNext  = IDLE;
      end
    end else begin
      case (state)
        WRITE: begin
          if (pixelValid && wordCount == CAPACITY) begin
            stateNext   = frameEnd ? IDLE : OVERRUN;
            droppedNext = frameEnd;
          end else begin
            if (pixelValid) begin
              writeEnableNext = 1'b1;
              addressNext     = {~readBank, wordCount[ADDRESS_WIDTH-1:0]};
              dataNext        = pixelData;
              wordCountNext   = wordCount + ONE;
            end
            if (frameEnd) begin
              frameDone  = 1'b1;
              finalCount = wordCountNext;
              stateNext  = IDLE;
            end
          end
        end
        OVERRUN: begin
          if (frameEnd) begin
            droppedNext = 1'b1;
            stateNext   = IDLE;
          end
        end
        default: ;
      endcase
    end

    // frameReady rises one cycle after the bank swap so the final write has committed
    released         = readerRelease | ~frameReady;
    handover         = frameDone & released;
    if (frameDone && !released)
      droppedNext = 1'b1;
    readBankNext     = handover ? ~readBank : readBank;
    frameLengthNext  = handover ? finalCount : frameLength;
    readyPendingNext = handover;
    if (handover)
      frameReadyNext = 1'b0;
    else if (readyPending)
      frameReadyNext = 1'b1;
    else if (readerRelease)
      frameReadyNext = 1'b0;
    else
      frameReadyNext = frameReady;
  end

`ifdef DOUBLE_BUFFER_STATS_EN
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)
      droppedCount <= '0;
    else if (droppedNext && droppedCount != 16'hFFFF)
      droppedCount <= droppedCount + 16'd1;
  end
`endif

endmodule

// File: tb/tb_double_buffer_writer.sv
// Bench for double_buffer_writer: directed frame scenarios plus random frames, checked against
// a frame-level model of bank ownership and an image of the SRAM built from port A writes.
module tb_double_buffer_writer;
  localparam int DW  = 10;
  localparam int AW  = 8;
  localparam int CAP = 1 << AW;

  logic          clock = 1'b0;
  logic          resetN;
  logic          frameStart, frameEnd, pixelValid, readerRelease;
  logic [DW-1:0] pixelData;
  logic          writeEnableA;
  logic [AW:0]   addressA;
  logic [DW-1:0] dataInA;
  logic          frameReady, readBank;
  logic [AW:0]   frameLength;
  logic          droppedFrame;
`ifdef DOUBLE_BUFFER_STATS_EN
  logic [15:0]   droppedCount;
`endif

  int vectors = 0;
  int miscompares = 0;
  int totalWrites = 0;
  int totalDrops = 0;
  int expDropTotal = 0;
  logic [DW-1:0] sram [0:2*CAP-1];
  logic        expReadBank = 1'b0;
  logic        expReady = 1'b0;
  logic [AW:0] expLength = '0;

  double_buffer_writer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clock(clock),
    .resetN(resetN),
    .frameStart(frameStart),
    .frameEnd(frameEnd),
    .pixelValid(pixelValid),
    .pixelData(pixelData),
    .readerRelease(readerRelease),
    .writeEnableA(writeEnableA),
    .addressA(addressA),
    .dataInA(dataInA),
    .frameReady(frameReady),
    .readBank(readBank),
    .frameLength(frameLength),
`ifdef DOUBLE_BUFFER_STATS_EN
    .droppedFrame(droppedFrame),
    .droppedCount(droppedCount)
`else
    .droppedFrame(droppedFrame)
`endif
  );

  always #5 clock = ~clock;

  // Plays the part of the SRAM behind port A and tallies write/drop pulses
  always @(posedge clock) begin
    if (writeEnableA) begin
      sram[addressA] <= dataInA;
      totalWrites    <= totalWrites + 1;
    end
    if (droppedFrame)
      totalDrops <= totalDrops + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fs, input logic fe, input logic pv,
                               input logic [DW-1:0] pd, input logic rr);
    frameStart    = fs;
    frameEnd      = fe;
    pixelValid    = pv;
    pixelData     = pd;
    readerRelease = rr;
    @(posedge clock);
    #1;
    frameStart    = 1'b0;
    frameEnd      = 1'b0;
    pixelValid    = 1'b0;
    pixelData     = '0;
    readerRelease = 1'b0;
  endtask

  // One whole frame of n pixels; the model decides handover vs discard from frame-level rules
  task automatic runFrame(input int n, input logic rel, input int base, input logic pixOnStart,
                          input logic pixOnEnd, input int gapPct, input int extraDrops);
    logic [DW-1:0] pix[$];
    int   writes0, drops0, sent, last, accepted, bad;
    logic wb, handover, dropped;
    pix = {};
    for (int i = 0; i < n; i++)
      pix.push_back(base < 0 ? DW'($urandom) : DW'(base + i));
    writes0 = totalWrites;
    drops0  = totalDrops;
    wb      = ~expReadBank;
    sent    = 0;
    if (pixOnStart && n > 0) begin
      applyStimulus(1'b1, 1'b0, 1'b1, pix[0], 1'b0);
      sent = 1;
      checkOutput("firstWrite.we", 32'(writeEnableA), 32'd1);
      checkOutput("firstWrite.addr", 32'(addressA), 32'({wb, {AW{1'b0}}}));
      checkOutput("firstWrite.data", 32'(dataInA), 32'(pix[0]));
    end else begin
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      checkOutput("startNoWrite", 32'(writeEnableA), 32'd0);
    end
    checkOutput("startDrop", 32'(droppedFrame), 32'(extraDrops));
    last = pixOnEnd ? n - 1 : n;
    while (sent < last) begin
      if (int'($urandom_range(99)) < gapPct) begin
        applyStimulus(1'b0, 1'b0, 1'b0, DW'($urandom), 1'b0);
      end else begin
        applyStimulus(1'b0, 1'b0, 1'b1, pix[sent], 1'b0);
        if (sent == 0) begin
          checkOutput("pixel0.we", 32'(writeEnableA), 32'd1);
          checkOutput("pixel0.addr", 32'(addressA), 32'({wb, {AW{1'b0}}}));
          checkOutput("pixel0.data", 32'(dataInA), 32'(pix[0]));
        end
        sent++;
      end
    end
    applyStimulus(1'b0, 1'b1, sent < n, (sent < n) ? pix[sent] : '0, rel);

    accepted = (n > CAP) ? CAP : n;
    handover = (n <= CAP) && (rel || !expReady);
    dropped  = ~handover;
    if (handover) begin
      expReadBank = ~expReadBank;
      expLength   = (AW+1)'(n);
    end
    checkOutput("end+1.readBank", 32'(readBank), 32'(expReadBank));
    checkOutput("end+1.frameLength", 32'(frameLength), 32'(expLength));
    if (handover || rel)
      expReady = 1'b0;
    checkOutput("end+1.frameReady", 32'(frameReady), 32'(expReady));
    checkOutput("end+1.droppedFrame", 32'(droppedFrame), 32'(dropped));
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    if (handover)
      expReady = 1'b1;
    checkOutput("end+2.frameReady", 32'(frameReady), 32'(expReady));
    checkOutput("end+2.droppedFrame", 32'(droppedFrame), 32'd0);
    checkOutput("writeCount", 32'(totalWrites - writes0), 32'(accepted));
    checkOutput("dropCount", 32'(totalDrops - drops0), 32'(int'(dropped) + extraDrops));
    expDropTotal += int'(dropped) + extraDrops;
    if (accepted > 0) begin
      bad = 0;
      for (int i = 0; i < accepted; i++)
        if (sram[{wb, AW'(i)}] !== pix[i]) bad++;
      checkOutput("bankData", 32'(bad), 32'd0);
    end
  endtask

  initial begin
    logic [DW-1:0] d;
    logic          wbExp;
    int            drops0;
    frameStart    = 1'b0;
    frameEnd      = 1'b0;
    pixelValid    = 1'b0;
    pixelData     = '0;
    readerRelease = 1'b0;
    resetN        = 1'b1;
    #2 resetN = 1'b0;
    #1;
    checkOutput("reset.we", 32'(writeEnableA), 32'd0);
    checkOutput("reset.addr", 32'(addressA), 32'd0);
    checkOutput("reset.data", 32'(dataInA), 32'd0);
    checkOutput("reset.frameReady", 32'(frameReady), 32'd0);
    checkOutput("reset.readBank", 32'(readBank), 32'd0);
    checkOutput("reset.frameLength", 32'(frameLength), 32'd0);
    checkOutput("reset.droppedFrame", 32'(droppedFrame), 32'd0);
    repeat (2) @(posedge clock);
    #1 resetN = 1'b1;

    // Full bank of ramp data, then a short frame nobody released
    runFrame(CAP, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    runFrame(10, 1'b0, 10, 1'b0, 1'b0, 0, 0);

    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    expReady = 1'b0;
    checkOutput("release.frameReady", 32'(frameReady), 32'd0);

    // Oversize frame, then a plain handover, then a release coinciding with frameEnd
    runFrame(300, 1'b0, -1, 1'b0, 1'b0, 10, 0);
    runFrame(7, 1'b0, -1, 1'b1, 1'b1, 0, 0);
    runFrame(5, 1'b1, -1, 1'b0, 1'b0, 0, 0);

    // Restart mid-frame
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    repeat (50) applyStimulus(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    runFrame(3, 1'b1, -1, 1'b0, 1'b0, 0, 1);

    // Start and end together: empty frame, then a one-pixel frame
    applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);
    expReadBank = ~expReadBank;
    expLength   = '0;
    checkOutput("empty.readBank", 32'(readBank), 32'(expReadBank));
    checkOutput("empty.frameLength", 32'(frameLength), 32'd0);
    checkOutput("empty.frameReady", 32'(frameReady), 32'd0);
    checkOutput("empty.we", 32'(writeEnableA), 32'd0);
    checkOutput("empty.droppedFrame", 32'(droppedFrame), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    expReady = 1'b1;
    checkOutput("empty+2.frameReady", 32'(frameReady), 32'd1);

    d     = DW'($urandom);
    wbExp = ~expReadBank;
    applyStimulus(1'b1, 1'b1, 1'b1, d, 1'b1);
    expReadBank = ~expReadBank;
    expLength   = (AW+1)'(1);
    checkOutput("single.we", 32'(writeEnableA), 32'd1);
    checkOutput("single.addr", 32'(addressA), 32'({wbExp, {AW{1'b0}}}));
    checkOutput("single.data", 32'(dataInA), 32'(d));
    checkOutput("single.readBank", 32'(readBank), 32'(expReadBank));
    checkOutput("single.frameLength", 32'(frameLength), 32'd1);
    checkOutput("single.frameReady", 32'(frameReady), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("single+2.frameReady", 32'(frameReady), 32'd1);

    for (int f = 0; f < 6; f++)
      runFrame(int'($urandom_range(300)), 1'($urandom_range(1)), -1,
               1'($urandom_range(1)), 1'($urandom_range(1)), 25, 0);

`ifdef DOUBLE_BUFFER_STATS_EN
    checkOutput("droppedCount", 32'(droppedCount), 32'(expDropTotal));
`endif

    // Reset in the middle of a frame
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    repeat (100) applyStimulus(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b0);
    drops0 = totalDrops;
    resetN = 1'b0;
    #1;
    checkOutput("midReset.we", 32'(writeEnableA), 32'd0);
    checkOutput("midReset.addr", 32'(addressA), 32'd0);
    checkOutput("midReset.data", 32'(dataInA), 32'd0);
    checkOutput("midReset.frameReady", 32'(frameReady), 32'd0);
    checkOutput("midReset.readBank", 32'(readBank), 32'd0);
    checkOutput("midReset.frameLength", 32'(frameLength), 32'd0);
    checkOutput("midReset.droppedFrame", 32'(droppedFrame), 32'd0);
`ifdef DOUBLE_BUFFER_STATS_EN
    checkOutput("midReset.droppedCount", 32'(droppedCount), 32'd0);
`endif
    repeat (2) @(posedge clock);
    #1 resetN = 1'b1;
    checkOutput("midReset.noDrop", 32'(totalDrops - drops0), 32'd0);
    expReadBank = 1'b0;
    expReady    = 1'b0;
    expLength   = '0;
    runFrame(int'($urandom_range(CAP, 1)), 1'b0, -1, 1'b1, 1'b0, 15, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
